// File: rtl/overlay_fetch.sv
// overlay_fetch
//   Read side of the overlay store. Fetches 32-bit words (two 16-bit {A,B,G,R}
//   pixels, low half first) from the overlay SDRAM channel into a small FIFO
//   and hands out one 4-bit RGBA pixel per active pixel strobe.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   enable                overlay present; low flushes everything and blanks pixels
//   ce_pix                one-clk pixel strobe
//   hblank, vblank        blanking; no pixel consumed while either is high
//   vsync                 rising edge restarts the frame at base_addr
//   base_addr             word address of pixel 0 (even)
//   mem_req / mem_addr    one-cycle read request and its word address
//   mem_ack / mem_dout    one-cycle response strobe and its data
//   pix_r/g/b/a           current overlay pixel
//   underrun              sticky: an active pixel found the FIFO empty
//
// Memory handshake: mem_req is a single-cycle pulse that carries mem_addr.
// At most one request is in flight; the matching mem_ack is a single-cycle
// pulse with mem_dout valid in that same cycle. An ack with nothing in
// flight is ignored. A request that was in flight when the frame restarted
// (or enable dropped) is still waited for, but its data is thrown away.
module overlay_fetch #(
  parameter int ADDR_W     = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              ce_pix,
  input  logic              hblank,
  input  logic              vblank,
  input  logic              vsync,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_dout,
  output logic [3:0]        pix_r,
  output logic [3:0]        pix_g,
  output logic [3:0]        pix_b,
  output logic [3:0]        pix_a,
  output logic              underrun
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [31:0]       fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              vsync_q, vsync_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic              pend_q, pend_d;
  logic              drop_q, drop_d;
  logic              half_q, half_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       pix_q, pix_d;
  logic              underrun_q, underrun_d;

  logic        fs, flush, ack_v, push, pop, consume, issue, fifo_empty;
  logic [31:0] head;

  assign fs         = vsync & ~vsync_q;
  // enable low acts like a frame start held every cycle
  assign flush      = fs | ~enable;
  assign ack_v      = mem_ack & pend_q;
  assign push       = ack_v & ~drop_q & ~flush;
  assign fifo_empty = (cnt_q == '0);
  assign consume    = ce_pix & ~hblank & ~vblank & enable & ~fs;
  // the head word is retired after its upper pixel has been shown
  assign pop        = consume & ~fifo_empty & half_q;
  // only one request in flight, so cnt_q + 1 <= depth guarantees room for its data
  assign issue      = enable & ~fs & ~pend_q & (cnt_q < CNT_W'(FIFO_DEPTH));
  assign head       = fifo_q[rd_ptr_q];

  always_comb begin
    vsync_d      = vsync;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    fetch_addr_d = fetch_addr_q;
    pend_d       = pend_q;
    drop_d       = drop_q;
    half_d       = half_q;
    mem_req_d    = issue;
    mem_addr_d   = mem_addr_q;
    pix_d        = pix_q;
    underrun_d   = underrun_q;

    if (ack_v) begin
      pend_d = 1'b0;
      drop_d = 1'b0;
    end

    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      cnt_d        = '0;
      half_d       = 1'b0;
      fetch_addr_d = base_addr;
      // an ack arriving right now retires the stale request itself
      if (pend_q && !mem_ack) drop_d = 1'b1;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
      if (issue) begin
        pend_d       = 1'b1;
        mem_addr_d   = fetch_addr_q;
        fetch_addr_d = fetch_addr_q + ADDR_W'(2);
      end
      if (consume) begin
        if (!fifo_empty) begin
          pix_d  = half_q ? head[31:16] : head[15:0];
          half_d = ~half_q;
        end else begin
          // lost slot: half and FIFO untouched, later pixels shift by one
          pix_d      = '0;
          underrun_d = 1'b1;
        end
      end
    end

    if (!enable) pix_d = '0;
    if (fs) underrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q      <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      fetch_addr_q <= '0;
      pend_q       <= 1'b0;
      drop_q       <= 1'b0;
      half_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      pix_q        <= '0;
      underrun_q   <= 1'b0;
    end else begin
      vsync_q      <= vsync_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      fetch_addr_q <= fetch_addr_d;
      pend_q       <= pend_d;
      drop_q       <= drop_d;
      half_q       <= half_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      pix_q        <= pix_d;
      underrun_q   <= underrun_d;
    end
  end

  // storage needs no reset: occupancy alone says what is valid
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= mem_dout;
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign pix_r    = pix_q[3:0];
  assign pix_g    = pix_q[7:4];
  assign pix_b    = pix_q[11:8];
  assign pix_a    = pix_q[15:12];
  assign underrun = underrun_q;

endmodule

// File: tb/tb_overlay_fetch.sv
// tb_overlay_fetch
//   Directed bench for overlay_fetch. Inputs change on the falling edge and
//   outputs are sampled there too. A memory model answers requests after a
//   programmable latency (or on an injected ack) with either a fixed word or
//   the pattern {addr+1, addr}, so pixel n of a frame reads as base + n.
module tb_overlay_fetch;
  localparam int ADDR_W     = 24;
  localparam int FIFO_DEPTH = 4;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset, enable, ce_pix, hblank, vblank, vsync;
  logic [ADDR_W-1:0] base_addr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [31:0]       mem_dout = '0;
  logic [3:0]        pix_r, pix_g, pix_b, pix_a;
  logic              underrun;
  logic [15:0]       pix;

  always #5 clk = ~clk;

  overlay_fetch #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ce_pix(ce_pix),
    .hblank(hblank), .vblank(vblank), .vsync(vsync), .base_addr(base_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_dout(mem_dout),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_a(pix_a), .underrun(underrun)
  );

  assign pix = {pix_a, pix_b, pix_g, pix_r};

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory model ----------------
  bit                mem_auto = 1'b1;
  int                mem_lat = 0;
  bit                mem_fixed_en = 1'b0;
  logic [31:0]       mem_fixed = 32'hA5C3_1F2E;
  bit                inj_ack = 1'b0;
  logic [31:0]       inj_data = '0;
  bit                mem_pend = 1'b0;
  int                mem_cnt = 0;
  logic [ADDR_W-1:0] mem_pend_addr = '0;
  int                overlap_cnt = 0;
  logic [ADDR_W-1:0] req_log[$];

  function automatic logic [31:0] pattern_word(input logic [ADDR_W-1:0] a);
    logic [15:0] lo;
    lo = a[15:0];
    return {lo + 16'd1, lo};
  endfunction

  function automatic logic [ADDR_W-1:0] log_at(input int i);
    if (i < req_log.size()) return req_log[i];
    return '1;
  endfunction

  // runs just after each falling edge, so stimulus set on that edge is seen
  always @(negedge clk) begin
    #1;
    mem_ack = 1'b0;
    if (inj_ack) begin
      mem_ack  = 1'b1;
      mem_dout = inj_data;
      mem_pend = 1'b0;
    end else if (mem_pend && mem_auto) begin
      if (mem_cnt == 0) begin
        mem_ack  = 1'b1;
        mem_dout = mem_fixed_en ? mem_fixed : pattern_word(mem_pend_addr);
        mem_pend = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    if (mem_req === 1'b1) begin
      if (mem_pend) overlap_cnt++;
      req_log.push_back(mem_addr);
      mem_pend      = 1'b1;
      mem_cnt       = mem_lat;
      mem_pend_addr = mem_addr;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe_check(input string tag, input logic [15:0] exp);
    ce_pix = 1'b1;
    step(1);
    ce_pix = 1'b0;
    check(tag, 32'(pix), 32'(exp));
    step(1);
  endtask

  logic [15:0] rec_pix [15];
  logic        rec_ur  [15];
  int          n0;

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; enable = 1'b0; ce_pix = 1'b0; hblank = 1'b1; vblank = 1'b1;
    vsync = 1'b0; base_addr = 24'h000100;
    step(3);
    check("rst_mem_req",  32'(mem_req),  32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_pix",      32'(pix),      32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    reset = 1'b0;
    step(1);

    // fill after frame start, zero-latency memory
    req_log.delete();
    enable = 1'b1; vsync = 1'b1;
    step(25);
    check("fill_req_cnt", 32'(req_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("fill_addr%0d", i), 32'(log_at(i)), 32'h100 + 32'(2 * i));
    check("fill_stop", 32'(mem_req), 32'd0);
    step(10);
    check("fill_hold", 32'(req_log.size()), 32'd4);

    // steady streaming: pixel order across many refilled words
    hblank = 1'b0; vblank = 1'b0;
    for (int i = 0; i < 24; i++) exp_q.push_back(16'(16'h0100 + i));
    for (int i = 0; i < 24; i++) strobe_check($sformatf("order%0d", i), exp_q.pop_front());
    hblank = 1'b1;
    ce_pix = 1'b1; step(1); ce_pix = 1'b0;
    check("blank_hold",  32'(pix),      32'h0117);
    check("no_underrun", 32'(underrun), 32'd0);

    // long latency: underrun from frame start, fixed word A5C3_1F2E
    step(20);
    mem_lat = 20; mem_fixed_en = 1'b1; vsync = 1'b0;
    step(1);
    vsync = 1'b1; hblank = 1'b0; vblank = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step(1); ce_pix = 1'b1;
      step(1); ce_pix = 1'b0;
      rec_pix[k] = pix; rec_ur[k] = underrun;
    end
    check("lat_first_pix",  32'(rec_pix[0]),  32'd0);
    check("lat_first_ur",   32'(rec_ur[0]),   32'd1);
    check("lat_ack_slot",   32'(rec_pix[11]), 32'd0);
    check("lat_lo_pix",     32'(rec_pix[12]), 32'h1F2E);
    check("lat_hi_pix",     32'(rec_pix[13]), 32'hA5C3);
    check("lat_after_pix",  32'(rec_pix[14]), 32'd0);
    check("lat_after_ur",   32'(rec_ur[14]),  32'd1);
    hblank = 1'b1; vblank = 1'b1;
    vsync = 1'b0; step(1);
    vsync = 1'b1; step(1);
    check("underrun_clear", 32'(underrun), 32'd0);

    // frame restart with a request in flight: its data is dropped
    enable = 1'b0;
    step(40);
    mem_auto = 1'b0; mem_lat = 0; mem_fixed_en = 1'b0;
    base_addr = 24'h000400; vsync = 1'b0;
    step(2);
    req_log.delete();
    enable = 1'b1;
    step(1);
    vsync = 1'b1;
    step(3);
    check("drop_single_out", 32'(req_log.size()), 32'd1);
    inj_data = 32'hFFFF_FFFF; inj_ack = 1'b1;
    step(1);
    inj_ack = 1'b0;
    step(2);
    check("drop_req_cnt", 32'(req_log.size()), 32'd2);
    check("drop_addr0",   32'(log_at(0)),      32'h400);
    check("drop_readdr",  32'(log_at(1)),      32'h400);
    hblank = 1'b0; vblank = 1'b0;
    ce_pix = 1'b1; step(1); ce_pix = 1'b0;
    check("drop_empty_pix", 32'(pix),      32'd0);
    check("drop_empty_ur",  32'(underrun), 32'd1);
    hblank = 1'b1;
    inj_data = 32'h1234_5678; inj_ack = 1'b1;
    step(1);
    inj_ack = 1'b0;
    step(1);
    hblank = 1'b0;
    ce_pix = 1'b1; step(1); ce_pix = 1'b0;
    check("drop_then_push", 32'(pix), 32'h5678);
    hblank = 1'b1; mem_auto = 1'b1;
    step(5);

    // enable dropped mid-line with three words buffered
    enable = 1'b0;
    step(10);
    base_addr = 24'h000800;
    step(2);
    req_log.delete();
    enable = 1'b1;
    step(25);
    check("en_first_addr", 32'(log_at(0)), 32'h800);
    hblank = 1'b0;
    ce_pix = 1'b1; step(1); ce_pix = 1'b0;
    check("en_pix0", 32'(pix), 32'h0800);
    step(1);
    ce_pix = 1'b1; step(1); ce_pix = 1'b0;
    check("en_pix1", 32'(pix), 32'h0801);
    enable = 1'b0;
    step(1);
    check("en_low_pix", 32'(pix), 32'd0);
    n0 = req_log.size();
    step(8);
    check("en_low_noreq", 32'(req_log.size()), 32'(n0));
    check("en_low_req",   32'(mem_req),        32'd0);
    enable = 1'b1; ce_pix = 1'b1;
    step(1);
    ce_pix = 1'b0;
    check("en_rise_empty", 32'(pix), 32'd0);
    step(2);
    check("en_restart_addr", 32'(log_at(n0)), 32'h800);
    hblank = 1'b1;
    step(20);
    hblank = 1'b0;
    for (int i = 0; i < 4; i++) strobe_check($sformatf("en_refill%0d", i), 16'(16'h0800 + i));

    // synchronous reset with a request in flight
    hblank = 1'b1;
    step(10);
    mem_auto = 1'b0; hblank = 1'b0;
    strobe_check("pre_rst_pix0", 16'h0804);
    strobe_check("pre_rst_pix1", 16'h0805);
    hblank = 1'b1;
    step(3);
    reset = 1'b1; vsync = 1'b0;
    step(1);
    check("mid_rst_mem_req",  32'(mem_req),  32'd0);
    check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_pix",      32'(pix),      32'd0);
    check("mid_rst_underrun", 32'(underrun), 32'd0);
    reset = 1'b0; req_log.delete();
    inj_data = 32'hBEEF_BEEF; inj_ack = 1'b1;
    step(1);
    inj_ack = 1'b0;
    step(1);
    inj_data = 32'h2468_1357; inj_ack = 1'b1;
    step(1);
    inj_ack = 1'b0; hblank = 1'b0;
    ce_pix = 1'b1; step(1); ce_pix = 1'b0;
    check("post_rst_addr", 32'(log_at(0)), 32'd0);
    check("post_rst_pix0", 32'(pix),       32'h1357);
    step(1);
    strobe_check("post_rst_pix1", 16'h2468);

    check("one_outstanding", 32'(overlap_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
